mux4_scan_ctrl: RTL and testbench
=================================

# mux4_scan_ctrl

Channel-scan controller that sits directly upstream of the team's 4:1 single-bit multiplexer. It drives the mux select lines through the enabled channels, holding each one for a fixed dwell time. At the end of each dwell it captures the mux output into a per-channel sample register. It signals completion of each sweep and supports single-sweep and continuous operation.

## Interface

Parameters:
- DWELL, default 4: cycles `sel` is held on each channel; legal range 1..255.
- CW, default 8: width of the dwell counter; must satisfy 2^CW > DWELL.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: begin a sweep; sampled only in IDLE.
- cont, input, 1: when 1 at sweep end, wrap and continue scanning.
- ch_en, input, 4: channel enable mask; bit i enables channel i.
- mux_out, input, 1: output of the downstream 4:1 mux, which is driven by `sel`.
- sel, output, 2: registered select to the downstream mux.
- busy, output, 1: high while in SCAN.
- sample, output, 4: bit i holds the last captured `mux_out` for channel i.
- frame_done, output, 1: one-cycle pulse at the end of each sweep.

## Operation

- There are two states: IDLE and SCAN. All outputs are registered.
- Reset values: state=IDLE, sel=2'b00, busy=0, sample=4'b0000, frame_done=0, dwell counter=0.

IDLE
- sel=00 and busy=0.
- If start=1 and ch_en!=0 at an edge:
  - sel ← lowest enabled index;
  - counter ← 0;
  - busy ← 1;
  - go to SCAN.
- start=1 with ch_en=0 is ignored; the block stays in IDLE.

SCAN
- The counter increments each cycle.
- At the edge where counter==DWELL-1:
  - sample[sel] ← mux_out; other sample bits are unchanged;
  - the block searches for the next enabled channel with index strictly greater than the current `sel`, using ch_en as it stands at that edge.
- If such a channel is found: sel ← that index, counter ← 0.
- If none is found, the sweep ends:
  - frame_done ← 1 for exactly one cycle.
  - If cont=1 and ch_en!=0: sel ← lowest enabled index, counter ← 0, stay in SCAN.
  - Otherwise: go to IDLE, sel ← 00, busy ← 0.
- start is ignored while in SCAN.
- Changing ch_en mid-dwell never aborts or shortens the current dwell. It takes effect only at the next advance decision.
- Disabling the current channel mid-dwell still completes and samples that channel.
- sample bits for channels not visited retain their previous values and are never cleared, except by rst.
- rst asserted at any time forces all reset values immediately; the in-progress dwell and sweep are discarded.

## Timing

- start accepted at edge k: sel is valid after edge k. The first capture happens at edge k+DWELL.
- The downstream mux is combinational, so mux_out settles within the cycle in which `sel` changes.
- Each channel occupies exactly DWELL cycles; there are no idle gap cycles between channels or between wrapped sweeps.
- A sweep over N enabled channels takes N·DWELL cycles:
  - the last capture and frame_done assertion occur at edge k+N·DWELL;
  - frame_done is high for the following cycle only;
  - busy falls at that same edge when not continuing.
- In IDLE after a sweep, a new start is accepted at the next edge at the earliest. The minimum gap between sweeps in single mode is therefore one cycle.
- DWELL=1: sel changes every cycle, and each cycle is a capture edge.

## Test plan

- Reset: assert rst mid-cycle with no clock → sel=00, busy=0, sample=0000, frame_done=0 immediately.
- Full single sweep:
  - Setup: DWELL=4, ch_en=1111, cont=0; mux data in0..in3=0,1,0,1.
  - Stimulus: pulse start.
  - Required response: sel steps 0,1,2,3, 4 cycles each; sample=4'b1010; frame_done pulses once, 16 cycles after start; busy drops on that edge; sel returns to 00.
- Sparse mask:
  - Setup: ch_en=0101, sample preloaded to 1010 from a previous sweep, all mux inputs 0.
  - Required response: sel visits 0 then 2 only; sweep length 8 cycles; final sample=1010 (bits 0 and 2 written 0, bits 1 and 3 unchanged).
- Continuous mode:
  - Setup: ch_en=1000, cont=1.
  - Required response: sel held at 11; frame_done pulses every 4 cycles with busy steady high.
  - Then deassert cont → block returns to IDLE at the next sweep end.
- Ignored starts:
  - start with ch_en=0000 → stays IDLE, busy=0.
  - start pulsed mid-sweep → sweep timing unchanged.
  - Clearing the current channel's ch_en bit mid-dwell → that channel is still sampled at the full DWELL.
- Reset mid-operation: assert rst during the second dwell of a 1111 sweep → immediate reset values, and no frame_done. After release, start runs a complete 16-cycle sweep.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
// Purpose: steps a 4:1 mux select through the enabled channels and samples the mux output per channel.
// Latency: sel is valid one cycle after start; each channel is captured DWELL cycles after its sel is driven.
// Backpressure: none; start is ignored while scanning, and the sweep runs to completion unless rst is asserted.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start              begin a sweep (sampled only when idle)
//   cont               wrap to the lowest enabled channel at sweep end instead of stopping
//   ch_en[3:0]         channel enable mask, bit i enables channel i
//   mux_out            output of the downstream mux, driven by sel
//   sel[1:0]           registered mux select
//   busy               high while scanning
//   sample[3:0]        last captured mux_out for each channel
//   frame_done         one-cycle pulse after each sweep's final capture
module mux4_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] ch_en,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] sample,
  output logic       frame_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic [3:0]    sample_q, sample_d;
  logic          frame_done_q, frame_done_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] low_idx;
  logic [1:0] next_idx;
  logic       next_vld;
  logic       any_en;
  logic       dwell_end;
  logic       wrap;

  assign any_en    = |ch_en;
  assign dwell_end = (state_q == SCAN) && (cnt_q == CW'(DWELL - 1));
  assign wrap      = cont && any_en;

  // Lowest enabled channel: scan downward so the smallest set index wins.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_en[i]) low_idx = 2'(i);
    end
  end

  // Next enabled channel strictly above the current one, using the live mask.
  always_comb begin
    next_vld = 1'b0;
    next_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_en[i] && (i > int'(sel_q))) begin
        next_vld = 1'b1;
        next_idx = 2'(i);
      end
    end
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 2'b00;
      busy_q       <= 1'b0;
      sample_q     <= 4'b0000;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      sample_q     <= sample_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && any_en) state_d = SCAN;
      SCAN: if (dwell_end && !next_vld && !wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    sel_d        = sel_q;
    busy_d       = busy_q;
    sample_d     = sample_q;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        sel_d  = 2'b00;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (start && any_en) begin
          sel_d  = low_idx;
          busy_d = 1'b1;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (dwell_end) begin
          // Capture the channel just dwelt on, even if its enable was dropped mid-dwell.
          sample_d[sel_q] = mux_out;
          cnt_d           = '0;
          if (next_vld) begin
            sel_d = next_idx;
          end else begin
            frame_done_d = 1'b1;
            if (wrap) begin
              sel_d = low_idx;
            end else begin
              sel_d  = 2'b00;
              busy_d = 1'b0;
            end
          end
        end
      end
      default: begin
        sel_d  = 2'b00;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    endcase
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign sample     = sample_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
module tb_mux4_scan_ctrl;

  localparam int DWELL = 4;
  localparam int CW    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] ch_en = 4'b0000;
  logic [3:0] mux_data = 4'b0000;
  logic       mux_out;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] sample;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  logic [1:0] sel_q[$];
  logic [3:0] smp_q[$];
  logic [3:0] model_sample = 4'b0000;

  // Behavioural stand-in for the downstream combinational 4:1 mux.
  assign mux_out = mux_data[sel];

  always #5 clk = ~clk;

  mux4_scan_ctrl #(.DWELL(DWELL), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .ch_en     (ch_en),
    .mux_out   (mux_out),
    .sel       (sel),
    .busy      (busy),
    .sample    (sample),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, {2'b00, sel}, 4'h0);
    chk({tag, "_busy"}, {3'b000, busy}, 4'h0);
    chk({tag, "_sample"}, sample, 4'h0);
    chk({tag, "_fd"}, {3'b000, frame_done}, 4'h0);
  endtask

  // Single-mode sweep; called at a negedge, returns at a negedge one cycle after the sweep end.
  task automatic sweep(input logic [3:0] en, input logic [3:0] data,
                       input int ms_idx, input int clr_idx, input int clr_bit);
    int         n;
    logic [1:0] s;
    logic [3:0] exp_smp;
    mux_data = data;
    ch_en    = en;
    cont     = 1'b0;
    exp_smp  = model_sample;
    n        = 0;
    for (int c = 0; c < 4; c++) begin
      if (en[c]) begin
        for (int d = 0; d < DWELL; d++) sel_q.push_back(2'(c));
        exp_smp[c] = data[c];
        n++;
      end
    end
    smp_q.push_back(exp_smp);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < n * DWELL; i++) begin
      @(negedge clk);
      s = sel_q.pop_front();
      chk("sweep_sel", {2'b00, sel}, {2'b00, s});
      chk("sweep_busy", {3'b000, busy}, 4'h1);
      chk("sweep_fd_low", {3'b000, frame_done}, 4'h0);
      start = (i == ms_idx);
      if (i == clr_idx) ch_en[clr_bit] = 1'b0;
      @(posedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    chk("end_fd", {3'b000, frame_done}, 4'h1);
    chk("end_busy", {3'b000, busy}, 4'h0);
    chk("end_sel", {2'b00, sel}, 4'h0);
    chk("end_sample", sample, smp_q.pop_front());
    model_sample = exp_smp;
    @(negedge clk);
    chk("post_fd", {3'b000, frame_done}, 4'h0);
    chk("post_busy", {3'b000, busy}, 4'h0);
  endtask

  initial begin
    // Reset applied before any clock edge.
    #1 rst = 1'b1;
    #1 chk_reset("rst_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full sweep, in0..in3 = 0,1,0,1, with a stray start mid-sweep.
    sweep(4'b1111, 4'b1010, 6, -1, 0);
    // Sparse mask, all inputs 0, sample preloaded to 1010.
    sweep(4'b0101, 4'b0000, -1, -1, 0);
    // Sparse mask writing ones into bits 0 and 2.
    sweep(4'b0101, 4'b0101, -1, -1, 0);
    // Clear channel 1's enable mid-dwell: it must still be sampled.
    sweep(4'b0011, 4'b0000, -1, 6, 1);

    // start with an empty mask is ignored.
    ch_en = 4'b0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("empty_busy", {3'b000, busy}, 4'h0);
      chk("empty_sel", {2'b00, sel}, 4'h0);
    end

    // Continuous mode on channel 3; cont dropped during the third sweep.
    ch_en    = 4'b1000;
    cont     = 1'b1;
    mux_data = 4'b0000;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("cont_sel0", {2'b00, sel}, 4'h3);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("cont_fd", {3'b000, frame_done}, {3'b000, (j % 4) == 0});
      chk("cont_busy", {3'b000, busy}, {3'b000, j < 12});
      chk("cont_sel", {2'b00, sel}, (j < 12) ? 4'h3 : 4'h0);
      if (j == 9) cont = 1'b0;
    end
    model_sample[3] = 1'b0;
    chk("cont_sample", sample, model_sample);
    @(negedge clk);
    chk("cont_post_fd", {3'b000, frame_done}, 4'h0);

    // Reset between edges while idle with a nonzero sample.
    #2 rst = 1'b1;
    #1 chk_reset("rst_idle");
    @(negedge clk);
    rst = 1'b0;
    model_sample = 4'b0000;

    // Reset during the second dwell of a 1111 sweep.
    ch_en    = 4'b1111;
    mux_data = 4'b0110;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_fd", {3'b000, frame_done}, 4'h0);
      chk("rst_hold_busy", {3'b000, busy}, 4'h0);
    end
    rst = 1'b0;
    sweep(4'b1111, 4'b0110, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
